// File: rtl/match_pkg.sv
// Shared encodings for the round/match sequencer: FSM states, winner codes,
// health width and a saturating win-counter increment.
package match_pkg;

  localparam int HEALTH_W = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ROUND_INIT = 3'd1,
    COUNTDOWN  = 3'd2,
    FIGHT      = 3'd3,
    ROUND_END  = 3'd4,
    MATCH_END  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_e;

  function automatic logic [1:0] inc_sat(input logic [1:0] w);
    return (w == 2'd3) ? w : w + 2'd1;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Frame-tick divider feeding a loadable down-counter of seconds that sticks at 0.
// The divider is cleared on load and whenever the counter is not running.
module sec_timer #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       load_i,
  input  logic [6:0] load_val_i,
  input  logic       run_i,
  output logic [6:0] timer_sec_o,
  output logic       zero_o
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

  logic [FW-1:0] frame_q, frame_d;
  logic [6:0]    sec_q, sec_d;

  always_comb begin
    frame_d = frame_q;
    sec_d   = sec_q;
    if (load_i) begin
      frame_d = '0;
      sec_d   = load_val_i;
    end else if (!run_i) begin
      frame_d = '0;
    end else if (frame_tick_i) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        if (sec_q != 7'd0) sec_d = sec_q - 7'd1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_q <= '0;
      sec_q   <= '0;
    end else begin
      frame_q <= frame_d;
      sec_q   <= sec_d;
    end
  end

  assign timer_sec_o = sec_q;
  assign zero_o      = (sec_q == 7'd0);

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: title -> countdown -> fight -> round end -> match end,
// with win counting, round clock, player-input gating and game-core re-arm pulse.
module match_controller
  import match_pkg::*;
#(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int ROUND_SECONDS   = 60,
  parameter int COUNTDOWN_SEC   = 3,
  parameter int WINS_TO_MATCH   = 2,
  parameter int MAX_ROUNDS      = 5,
  parameter int END_HOLD_FRAMES = 120
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                start,
  input  logic [HEALTH_W-1:0] p1_health,
  input  logic [HEALTH_W-1:0] p2_health,
  output logic                game_rst,
  output logic                fight_en,
  output logic [2:0]          state,
  output logic [2:0]          round_num,
  output logic [1:0]          p1_wins,
  output logic [1:0]          p2_wins,
  output logic [6:0]          timer_sec,
  output logic [1:0]          winner
);

  localparam int HW = $clog2(END_HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(END_HOLD_FRAMES - 1);
  localparam logic [1:0]    WINS_L    = 2'(WINS_TO_MATCH);
  localparam logic [2:0]    MAXR_L    = 3'(MAX_ROUNDS);
  localparam logic [6:0]    CD_L      = 7'(COUNTDOWN_SEC);
  localparam logic [6:0]    RS_L      = 7'(ROUND_SECONDS);

  state_e        state_q, state_d;
  winner_e       winner_q, winner_d, outcome;
  logic [2:0]    round_q, round_d;
  logic [1:0]    p1w_q, p1w_d, p2w_q, p2w_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          start_q, start_rise;
  logic          game_rst_q, fight_en_q;
  logic          tmr_load, tmr_run, tmr_zero;
  logic [6:0]    tmr_val;

  assign start_rise = start & ~start_q;

  // Round verdict, only acted upon while in FIGHT; KO takes precedence over timeout.
  always_comb begin
    outcome = W_NONE;
    if (p1_health == '0 && p2_health == '0)      outcome = W_DRAW;
    else if (p1_health == '0)                    outcome = W_P2;
    else if (p2_health == '0)                    outcome = W_P1;
    else if (tmr_zero) begin
      if (p1_health > p2_health)                 outcome = W_P1;
      else if (p1_health < p2_health)            outcome = W_P2;
      else                                       outcome = W_DRAW;
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    p1w_d    = p1w_q;
    p2w_d    = p2w_q;
    winner_d = winner_q;
    hold_d   = '0;
    tmr_load = 1'b0;
    tmr_val  = CD_L;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = ROUND_INIT;
          round_d = 3'd1;
          p1w_d   = 2'd0;
          p2w_d   = 2'd0;
        end
      end
      ROUND_INIT: state_d = COUNTDOWN;
      COUNTDOWN: begin
        if (tmr_zero) begin
          state_d  = FIGHT;
          tmr_load = 1'b1;
          tmr_val  = RS_L;
        end
      end
      FIGHT: begin
        if (outcome != W_NONE) begin
          state_d  = ROUND_END;
          winner_d = outcome;
          if (outcome == W_P1) p1w_d = inc_sat(p1w_q);
          if (outcome == W_P2) p2w_d = inc_sat(p2w_q);
        end
      end
      ROUND_END: begin
        hold_d = hold_q;
        if (frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (p1w_q == WINS_L || p2w_q == WINS_L || round_q == MAXR_L) begin
              state_d = MATCH_END;
              if (p1w_q > p2w_q)      winner_d = W_P1;
              else if (p2w_q > p1w_q) winner_d = W_P2;
              else                    winner_d = W_DRAW;
            end else begin
              state_d = ROUND_INIT;
              round_d = round_q + 3'd1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      MATCH_END: begin
        if (start_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // ROUND_INIT lasts one cycle, so being the next state always means a fresh entry.
    if (state_d == ROUND_INIT) begin
      tmr_load = 1'b1;
      tmr_val  = CD_L;
      winner_d = W_NONE;
    end
  end

  // The clock only runs while staying in COUNTDOWN/FIGHT, so it freezes on the decision cycle.
  assign tmr_run = (state_q == COUNTDOWN || state_q == FIGHT) && (state_d == state_q);

  sec_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_sec_timer (
    .clk_i       (clk),
    .rst_i       (reset),
    .frame_tick_i(frame_tick),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .run_i       (tmr_run),
    .timer_sec_o (timer_sec),
    .zero_o      (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      round_q    <= 3'd1;
      p1w_q      <= 2'd0;
      p2w_q      <= 2'd0;
      winner_q   <= W_NONE;
      hold_q     <= '0;
      start_q    <= 1'b0;
      game_rst_q <= 1'b0;
      fight_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      p1w_q      <= p1w_d;
      p2w_q      <= p2w_d;
      winner_q   <= winner_d;
      hold_q     <= hold_d;
      start_q    <= start;
      game_rst_q <= (state_d == ROUND_INIT);
      fight_en_q <= (state_d == FIGHT);
    end
  end

  assign state     = state_q;
  assign round_num = round_q;
  assign p1_wins   = p1w_q;
  assign p2_wins   = p2w_q;
  assign winner    = winner_q;
  assign game_rst  = game_rst_q;
  assign fight_en  = fight_en_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: expected state entries are queued by the
// stimulus thread and compared by a monitor whenever the DUT changes state.
module tb_match_controller;
  import match_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [3:0] p1_health = 4'd8;
  logic [3:0] p2_health = 4'd8;
  logic       game_rst, fight_en;
  logic [2:0] state, round_num;
  logic [1:0] p1_wins, p2_wins, winner;
  logic [6:0] timer_sec;

  int vectors = 0;
  int miscompares = 0;
  int gr_cycles = 0;

  typedef struct {
    logic [2:0] st;
    logic [2:0] rnd;
    logic [1:0] p1w;
    logic [1:0] p2w;
    logic [1:0] win;
    logic [6:0] tmr;
    bit         ck_tmr;
    bit         ck_ctr;
  } exp_t;

  exp_t expq[$];

  match_controller #(
    .FRAMES_PER_SEC(4), .ROUND_SECONDS(60), .COUNTDOWN_SEC(3),
    .WINS_TO_MATCH(2), .MAX_ROUNDS(5), .END_HOLD_FRAMES(4)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .p1_health(p1_health), .p2_health(p2_health),
    .game_rst(game_rst), .fight_en(fight_en), .state(state),
    .round_num(round_num), .p1_wins(p1_wins), .p2_wins(p2_wins),
    .timer_sec(timer_sec), .winner(winner)
  );

  always #5 clk = ~clk;

  // One frame_tick every 10 clocks.
  initial begin
    forever begin
      repeat (9) @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [2:0] rnd, input logic [1:0] p1w,
                      input logic [1:0] p2w, input logic [1:0] win, input logic [6:0] tmr,
                      input bit ck_tmr, input bit ck_ctr);
    exp_t e;
    e.st = st; e.rnd = rnd; e.p1w = p1w; e.p2w = p2w; e.win = win; e.tmr = tmr;
    e.ck_tmr = ck_tmr; e.ck_ctr = ck_ctr;
    expq.push_back(e);
  endtask

  task automatic push_round(input logic [2:0] rnd, input logic [1:0] p1w, input logic [1:0] p2w);
    push(ROUND_INIT, rnd, p1w, p2w, W_NONE, 7'd3, 1'b1, 1'b1);
    push(COUNTDOWN,  rnd, p1w, p2w, W_NONE, 7'd3, 1'b1, 1'b1);
    push(FIGHT,      rnd, p1w, p2w, W_NONE, 7'd60, 1'b1, 1'b1);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (state != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state != st) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out in state %0d, required state %0d", name, state, st);
    end
  endtask

  task automatic wait_timer(input logic [6:0] val, input int budget, input string name);
    int n = 0;
    while (timer_sec != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (timer_sec != val) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out with timer %0d, required %0d", name, timer_sec, val);
    end
  endtask

  task automatic measure_timer(input logic [6:0] val, input int budget, output int n);
    n = 0;
    while (timer_sec == val && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for FIGHT, applies the health pair, expects ROUND_END, then restores health.
  task automatic fight_outcome(input logic [3:0] h1, input logic [3:0] h2, input logic [2:0] rnd,
                               input logic [1:0] p1w, input logic [1:0] p2w,
                               input logic [1:0] win, input int budget);
    push(ROUND_END, rnd, p1w, p2w, win, 7'd0, 1'b0, 1'b1);
    wait_state(FIGHT, 300, "reach_fight");
    @(posedge clk);
    #1 begin p1_health = h1; p2_health = h2; end
    wait_state(ROUND_END, budget, "reach_round_end");
    check("fight_en_drop", fight_en, 0);
    fork
      begin
        @(posedge clk);
        #1 begin p1_health = 4'd8; p2_health = 4'd8; end
      end
    join_none
  endtask

  // Monitor: every state change must match the next queued expectation.
  initial begin
    exp_t       e;
    logic       ok;
    logic [2:0] prev_st;
    prev_st = 3'd0;
    forever begin
      @(negedge clk);
      if (game_rst) gr_cycles++;
      if (state != prev_st) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_transition: state %0d -> %0d, required no transition", prev_st, state);
        end else begin
          e  = expq.pop_front();
          ok = (state == e.st) && (fight_en == (e.st == FIGHT)) && (game_rst == (e.st == ROUND_INIT));
          if (e.ck_ctr && (round_num != e.rnd || p1_wins != e.p1w || p2_wins != e.p2w || winner != e.win))
            ok = 1'b0;
          if (e.ck_tmr && timer_sec != e.tmr) ok = 1'b0;
          if (!ok) begin
            miscompares++;
            $display("FAIL transition: got st=%0d rnd=%0d wins=%0d/%0d win=%0d tmr=%0d fe=%0d gr=%0d, required st=%0d rnd=%0d wins=%0d/%0d win=%0d tmr=%0d",
                     state, round_num, p1_wins, p2_wins, winner, timer_sec, fight_en, game_rst,
                     e.st, e.rnd, e.p1w, e.p2w, e.win, e.tmr);
          end
        end
        prev_st = state;
      end
    end
  end

  initial begin
    int n;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_state", state, IDLE);
    check("rst_game_rst", game_rst, 0);
    check("rst_fight_en", fight_en, 0);
    check("rst_round", round_num, 1);
    check("rst_p1_wins", p1_wins, 0);
    check("rst_p2_wins", p2_wins, 0);
    check("rst_timer", timer_sec, 0);
    check("rst_winner", winner, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Start held for 200 clocks; countdown cadence and entry into FIGHT.
    push_round(3'd1, 2'd0, 2'd0);
    gr_cycles = 0;
    @(posedge clk);
    #1 start = 1'b1;
    fork
      begin
        repeat (200) @(posedge clk);
        #1 start = 1'b0;
      end
    join_none
    wait_state(COUNTDOWN, 10, "enter_countdown");
    wait_timer(7'd2, 100, "countdown_2");
    measure_timer(7'd2, 100, n);
    check("cd2_len", n, 40);
    measure_timer(7'd1, 100, n);
    check("cd1_len", n, 40);
    check("cd0_state", state, COUNTDOWN);
    check("cd0_timer", timer_sec, 0);
    check("cd0_fight_en", fight_en, 0);
    @(negedge clk);
    check("fight_state", state, FIGHT);
    check("fight_en_rise", fight_en, 1);
    check("fight_timer", timer_sec, 60);
    n = 0;
    while (start && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("start_released", start, 0);
    check("game_rst_cycles", gr_cycles, 1);

    // Match A: P1 KO win, double KO, timeout draw, P1 KO win -> match to P1.
    fight_outcome(4'd8, 4'd0, 3'd1, 2'd1, 2'd0, W_P1, 100);
    push_round(3'd2, 2'd1, 2'd0);
    n = 0;
    while (state == ROUND_END && n < 100) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n < 31 || n > 40) begin
      miscompares++;
      $display("FAIL round_end_len: got %0d clks, required 31..40", n);
    end
    check("r2_round", round_num, 2);
    check("r2_game_rst", game_rst, 1);
    fight_outcome(4'd0, 4'd0, 3'd2, 2'd1, 2'd0, W_DRAW, 100);
    push_round(3'd3, 2'd1, 2'd0);
    fight_outcome(4'd5, 4'd5, 3'd3, 2'd1, 2'd0, W_DRAW, 3000);
    check("timeout_timer", timer_sec, 0);
    push_round(3'd4, 2'd1, 2'd0);
    fight_outcome(4'd8, 4'd0, 3'd4, 2'd2, 2'd0, W_P1, 100);
    push(MATCH_END, 3'd4, 2'd2, 2'd0, W_P1, 7'd0, 1'b0, 1'b1);
    wait_state(MATCH_END, 100, "matchA_end");
    check("matchA_winner", winner, W_P1);

    // Match B: P1 takes rounds 1 and 2.
    push(IDLE, 3'd0, 2'd0, 2'd0, W_NONE, 7'd0, 1'b0, 1'b0);
    pulse_start();
    wait_state(IDLE, 10, "matchB_idle");
    push_round(3'd1, 2'd0, 2'd0);
    pulse_start();
    fight_outcome(4'd8, 4'd0, 3'd1, 2'd1, 2'd0, W_P1, 100);
    push_round(3'd2, 2'd1, 2'd0);
    fight_outcome(4'd9, 4'd0, 3'd2, 2'd2, 2'd0, W_P1, 100);
    push(MATCH_END, 3'd2, 2'd2, 2'd0, W_P1, 7'd0, 1'b0, 1'b1);
    wait_state(MATCH_END, 100, "matchB_end");
    check("matchB_winner", winner, W_P1);
    check("matchB_round", round_num, 2);

    // Match C: five double-KO draws run into the round limit.
    push(IDLE, 3'd0, 2'd0, 2'd0, W_NONE, 7'd0, 1'b0, 1'b0);
    pulse_start();
    wait_state(IDLE, 10, "matchC_idle");
    push_round(3'd1, 2'd0, 2'd0);
    pulse_start();
    for (int r = 1; r <= 5; r++) begin
      fight_outcome(4'd0, 4'd0, 3'(r), 2'd0, 2'd0, W_DRAW, 100);
      if (r < 5) push_round(3'(r + 1), 2'd0, 2'd0);
      else       push(MATCH_END, 3'd5, 2'd0, 2'd0, W_DRAW, 7'd0, 1'b0, 1'b1);
    end
    wait_state(MATCH_END, 100, "matchC_end");
    check("matchC_winner", winner, W_DRAW);
    check("matchC_round", round_num, 5);
    check("matchC_p1_wins", p1_wins, 0);

    // Match D: asynchronous reset in the middle of round 2.
    push(IDLE, 3'd0, 2'd0, 2'd0, W_NONE, 7'd0, 1'b0, 1'b0);
    pulse_start();
    wait_state(IDLE, 10, "matchD_idle");
    push_round(3'd1, 2'd0, 2'd0);
    pulse_start();
    fight_outcome(4'd8, 4'd0, 3'd1, 2'd1, 2'd0, W_P1, 100);
    push_round(3'd2, 2'd1, 2'd0);
    wait_state(FIGHT, 300, "matchD_fight");
    push(IDLE, 3'd1, 2'd0, 2'd0, W_NONE, 7'd0, 1'b1, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_state", state, IDLE);
    check("arst_fight_en", fight_en, 0);
    check("arst_game_rst", game_rst, 0);
    check("arst_round", round_num, 1);
    check("arst_p1_wins", p1_wins, 0);
    check("arst_timer", timer_sec, 0);
    check("arst_winner", winner, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
